// File: rtl/display_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_mode_sequencer_pkg
// Description : Shared state encodings, widths and colour scaling helper
// Revision    : 1.0
// ============================================================================
package display_mode_sequencer_pkg;

  localparam int COLOR_W = 4;
  localparam int LVL_W   = 4;
  localparam int LVL_MAX = 15;

  localparam logic [1:0] SHOW     = 2'd0;
  localparam logic [1:0] FADE_OUT = 2'd1;
  localparam logic [1:0] SWITCH   = 2'd2;
  localparam logic [1:0] FADE_IN  = 2'd3;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // c * (lvl+1) / 16: lvl=15 passes c through unchanged, lvl=0 gives black.
  function automatic logic [COLOR_W-1:0] scale_color(
    input logic [COLOR_W-1:0] c,
    input logic [LVL_W-1:0]   lvl
  );
    logic [2*COLOR_W-1:0] prod;
    prod = (2*COLOR_W)'(c) * (2*COLOR_W)'({1'b0, lvl} + (LVL_W+1)'(1));
    return COLOR_W'(prod >> COLOR_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_dimmer.sv
`default_nettype none
// ============================================================================
// Module      : display_dimmer
// Description : Registered three-channel brightness scaler
// Revision    : 1.0
// ============================================================================
module display_dimmer
  import display_mode_sequencer_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [LVL_W-1:0]   i_lvl,
  input  logic [COLOR_W-1:0] i_r,
  input  logic [COLOR_W-1:0] i_g,
  input  logic [COLOR_W-1:0] i_b,
  output logic [COLOR_W-1:0] o_r,
  output logic [COLOR_W-1:0] o_g,
  output logic [COLOR_W-1:0] o_b
);

  rgb_t w_rgb_d;
  rgb_t r_rgb_q;

  always_comb begin
    w_rgb_d.r = scale_color(i_r, i_lvl);
    w_rgb_d.g = scale_color(i_g, i_lvl);
    w_rgb_d.b = scale_color(i_b, i_lvl);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rgb_q <= '0;
    end else begin
      r_rgb_q <= w_rgb_d;
    end
  end

  assign o_r = r_rgb_q.r;
  assign o_g = r_rgb_q.g;
  assign o_b = r_rgb_q.b;

endmodule
`default_nettype wire

// File: rtl/display_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : display_mode_sequencer
// Description : Frame-synchronous pattern selector with fade-out/switch/fade-in
// Revision    : 1.0
// ============================================================================
module display_mode_sequencer
  import display_mode_sequencer_pkg::*;
#(
  parameter int N_MODES          = 4,
  parameter int HOLD_FRAMES      = 300,
  parameter int FADE_STEP_FRAMES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame,
  input  logic                      i_next,
  input  logic                      i_hold,
  input  logic [COLOR_W-1:0]        i_r,
  input  logic [COLOR_W-1:0]        i_g,
  input  logic [COLOR_W-1:0]        i_b,
  output logic [$clog2(N_MODES):0]  o_mode,
  output logic [COLOR_W-1:0]        o_r,
  output logic [COLOR_W-1:0]        o_g,
  output logic [COLOR_W-1:0]        o_b,
  output logic                      o_busy
);

  localparam int MODE_W = $clog2(N_MODES) + 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES) + 1;
  localparam int STEP_W = $clog2(FADE_STEP_FRAMES) + 1;

  localparam logic [MODE_W-1:0] c_MODE_LAST = MODE_W'(N_MODES - 1);
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [STEP_W-1:0] c_STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
  localparam logic [LVL_W-1:0]  c_LVL_TOP   = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0]  c_LVL_PRE   = LVL_W'(LVL_MAX - 1);

  logic [1:0]        r_state_q,   w_state_d;
  logic [LVL_W-1:0]  r_lvl_q,     w_lvl_d;
  logic [MODE_W-1:0] r_mode_q,    w_mode_d;
  logic [HOLD_W-1:0] r_hold_q,    w_hold_d;
  logic [STEP_W-1:0] r_step_q,    w_step_d;
  logic              r_pending_q, w_pending_d;
  logic              r_busy_q,    w_busy_d;
  logic              w_enter_fade;

  always_comb begin
    w_state_d    = r_state_q;
    w_lvl_d      = r_lvl_q;
    w_mode_d     = r_mode_q;
    w_hold_d     = r_hold_q;
    w_step_d     = r_step_q;
    w_enter_fade = 1'b0;

    if (i_frame) begin
      case (r_state_q)
        SHOW: begin
          if (r_pending_q || (r_hold_q == c_HOLD_LAST && !i_hold)) begin
            w_state_d    = FADE_OUT;
            w_hold_d     = '0;
            w_step_d     = '0;
            w_enter_fade = 1'b1;
          end else if (r_hold_q != c_HOLD_LAST) begin
            // Saturate so a timeout held off by i_hold fires as soon as it drops.
            w_hold_d = r_hold_q + HOLD_W'(1);
          end
        end
        FADE_OUT: begin
          if (r_step_q == c_STEP_LAST) begin
            w_step_d = '0;
            w_lvl_d  = r_lvl_q - LVL_W'(1);
            if (r_lvl_q == LVL_W'(1)) begin
              w_state_d = SWITCH;
            end
          end else begin
            w_step_d = r_step_q + STEP_W'(1);
          end
        end
        SWITCH: begin
          w_mode_d  = (r_mode_q == c_MODE_LAST) ? '0 : r_mode_q + MODE_W'(1);
          w_step_d  = '0;
          w_state_d = FADE_IN;
        end
        FADE_IN: begin
          if (r_step_q == c_STEP_LAST) begin
            w_step_d = '0;
            w_lvl_d  = r_lvl_q + LVL_W'(1);
            if (r_lvl_q == c_LVL_PRE) begin
              w_state_d = SHOW;
              w_hold_d  = '0;
            end
          end else begin
            w_step_d = r_step_q + STEP_W'(1);
          end
        end
        default: begin
          w_state_d = SHOW;
        end
      endcase
    end

    // A request arriving with the fade-out entry is swallowed by that transition.
    w_pending_d = w_enter_fade ? 1'b0 : (r_pending_q | i_next);
    w_busy_d    = (w_state_d != SHOW);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state_q   <= SHOW;
      r_lvl_q     <= c_LVL_TOP;
      r_mode_q    <= '0;
      r_hold_q    <= '0;
      r_step_q    <= '0;
      r_pending_q <= 1'b0;
      r_busy_q    <= 1'b0;
    end else begin
      r_state_q   <= w_state_d;
      r_lvl_q     <= w_lvl_d;
      r_mode_q    <= w_mode_d;
      r_hold_q    <= w_hold_d;
      r_step_q    <= w_step_d;
      r_pending_q <= w_pending_d;
      r_busy_q    <= w_busy_d;
    end
  end

  display_dimmer u_dimmer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_lvl (r_lvl_q),
    .i_r   (i_r),
    .i_g   (i_g),
    .i_b   (i_b),
    .o_r   (o_r),
    .o_g   (o_g),
    .o_b   (o_b)
  );

  assign o_mode = r_mode_q;
  assign o_busy = r_busy_q;

endmodule
`default_nettype wire
